// File: rtl/nem_ohmux_sel_arb_if.sv
// Request/select bundle between datapath clients and the NEM-relay select arbiter.
// master: clients drive REQ0/REQ1. slave: arbiter drives S0/S1, GNT0/GNT1 and BUSY.
interface nem_ohmux_sel_arb_if;
    logic REQ0;
    logic REQ1;
    logic S0;
    logic S1;
    logic GNT0;
    logic GNT1;
    logic BUSY;

    modport master (
        output REQ0,
        output REQ1,
        input  S0,
        input  S1,
        input  GNT0,
        input  GNT1,
        input  BUSY
    );

    modport slave (
        input  REQ0,
        input  REQ1,
        output S0,
        output S1,
        output GNT0,
        output GNT1,
        output BUSY
    );
endinterface

// File: rtl/nem_ohmux_sel_arb.sv
// Round-robin arbiter/sequencer for the one-hot S0/S1 select pair of a NEM-relay mux bank.
// Ports: CP clock, RST async active-high reset, bus (slave) carries REQx in and Sx/GNTx/BUSY out.
module nem_ohmux_sel_arb #(
    parameter int unsigned SETTLE_CYC  = 8,
    parameter int unsigned RELEASE_CYC = 4,
    parameter int unsigned HOLD_MAX    = 16
) (
    input  logic                CP,
    input  logic                RST,
    nem_ohmux_sel_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAKE  = 2'd1,
        GRANT = 2'd2,
        BREAK = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_LD  = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] RELEASE_LD = 8'(RELEASE_CYC - 1);
    localparam logic [7:0] HOLD_LIM   = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);
    localparam logic       PREEMPT_EN = (HOLD_MAX != 0);

    state_t     state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [7:0] hold_q,  hold_d;
    logic       own_q,   own_d;
    logic       last_q,  last_d;
    logic       s0_q,    s0_d;
    logic       s1_q,    s1_d;
    logic       gnt0_q,  gnt0_d;
    logic       gnt1_q,  gnt1_d;

    // Select / grant asserted for the owner after this edge; mapped to
    // the port selected by own_d so only one select can ever be driven.
    logic       s_on_d;
    logic       g_on_d;

    logic       req_own;
    logic       req_oth;
    logic       win;

    assign req_own = own_q ? bus.REQ1 : bus.REQ0;
    assign req_oth = own_q ? bus.REQ0 : bus.REQ1;

    // Sole requester wins; on a tie the port not served last wins.
    assign win = (bus.REQ0 && bus.REQ1) ? ~last_q : bus.REQ1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        own_d   = own_q;
        last_d  = last_q;
        s_on_d  = 1'b0;
        g_on_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.REQ0 || bus.REQ1) begin
                    state_d = MAKE;
                    own_d   = win;
                    last_d  = win;
                    cnt_d   = SETTLE_LD;
                    s_on_d  = 1'b1;
                end
            end

            MAKE: begin
                if (!req_own) begin
                    // Requester gave up while the relay was still pulling in.
                    state_d = BREAK;
                    cnt_d   = RELEASE_LD;
                end else if (cnt_q == 8'd0) begin
                    state_d = GRANT;
                    hold_d  = 8'd0;
                    s_on_d  = 1'b1;
                    g_on_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                    s_on_d  = 1'b1;
                end
            end

            GRANT: begin
                if (!req_own) begin
                    state_d = BREAK;
                    cnt_d   = RELEASE_LD;
                end else if (PREEMPT_EN && req_oth && (hold_q >= HOLD_LIM)) begin
                    // Bounded hold under contention: force the path open.
                    state_d = BREAK;
                    cnt_d   = RELEASE_LD;
                end else begin
                    s_on_d  = 1'b1;
                    g_on_d  = 1'b1;
                    if (hold_q != 8'hff) begin
                        hold_d = hold_q + 8'd1;
                    end
                end
            end

            BREAK: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = BREAK;
                cnt_d   = RELEASE_LD;
            end
        endcase

        s0_d   = s_on_d & ~own_d;
        s1_d   = s_on_d &  own_d;
        gnt0_d = g_on_d & ~own_d;
        gnt1_d = g_on_d &  own_d;
    end

    // Reset lands in BREAK so a reset taken mid-operation still
    // honours the relay dead time before any select rises again.
    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            state_q <= BREAK;
            cnt_q   <= RELEASE_LD;
            hold_q  <= 8'd0;
            own_q   <= 1'b0;
            last_q  <= 1'b1;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            own_q   <= own_d;
            last_q  <= last_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
        end
    end

    assign bus.S0   = s0_q;
    assign bus.S1   = s1_q;
    assign bus.GNT0 = gnt0_q;
    assign bus.GNT1 = gnt1_q;
    assign bus.BUSY = (state_q != IDLE);

endmodule
